pci_bus_arbiter: RTL and testbench

- Central round-robin arbiter that shares the PCI AD/CBE bus between NUM_MASTERS initiators.
- Watches the shared active-low FRAME#/IRDY# lines to track bus occupancy.
- Drives one active-low GNT# per master and parks the bus on a default master when idle.
- Sits beside the target buffer; only the granted initiator may start a FRAME# cycle towards it.

---
 rtl/pci_bus_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_pci_bus_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pci_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pci_bus_arbiter
// Description : Round-robin PCI bus arbiter with bus parking and idle-grant
//               timeout; watches FRAME#/IRDY# to track bus occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module pci_bus_arbiter #(
    parameter int NUM_MASTERS  = 4,
    parameter int PARK_MASTER  = 0,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         req_n,
    input  logic                           frame_n,
    input  logic                           irdy_n,
    output logic [NUM_MASTERS-1:0]         gnt_n,
    output logic [$clog2(NUM_MASTERS)-1:0] owner_id,
    output logic                           bus_busy,
    output logic                           timeout
);

    localparam int IDW = $clog2(NUM_MASTERS);
    localparam int TW  = $clog2(IDLE_TIMEOUT);

    localparam logic [IDW-1:0] PARK_ID   = IDW'(PARK_MASTER);
    localparam logic [IDW-1:0] LAST_RST  = IDW'(NUM_MASTERS - 1);
    localparam logic [TW-1:0]  TIMER_MAX = TW'(IDLE_TIMEOUT - 1);

    localparam logic [1:0] ST_PARK    = 2'd0;
    localparam logic [1:0] ST_TURN    = 2'd1;
    localparam logic [1:0] ST_GRANTED = 2'd2;
    localparam logic [1:0] ST_BUSY    = 2'd3;

    logic [1:0]             state_q,     state_d;
    logic [NUM_MASTERS-1:0] gnt_q,       gnt_d;
    logic [IDW-1:0]         owner_q,     owner_d;
    logic [IDW-1:0]         last_q,      last_d;
    logic [IDW-1:0]         pending_q,   pending_d;
    logic                   pend_park_q, pend_park_d;
    logic                   busy_q,      busy_d;
    logic                   timeout_q,   timeout_d;
    logic [TW-1:0]          timer_q,     timer_d;

    logic                   w_idle;
    logic                   w_expire;
    logic [IDW-1:0]         w_base;
    logic [IDW:0]           w_pick;
    logic                   w_any;
    logic [IDW-1:0]         w_win;
    logic [1:0]             w_arb_state;
    logic [IDW-1:0]         w_arb_pending;
    logic                   w_arb_park;

    // First requester scanning upward from base+1 with wrap; base itself is checked last.
    function automatic logic [IDW:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                             input logic [IDW-1:0]         base);
        logic [IDW:0]   pick;
        logic [IDW-1:0] idx;
        pick = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx = IDW'((int'(base) + i) % NUM_MASTERS);
            if (!req[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

    assign w_idle   = frame_n & irdy_n;
    assign w_expire = (state_q == ST_GRANTED) && frame_n && !req_n[owner_q]
                      && (timer_q == TIMER_MAX);
    assign w_base   = (((state_q == ST_GRANTED) && !req_n[owner_q]) || (state_q == ST_BUSY))
                      ? owner_q : last_q;
    assign w_pick   = rr_pick(req_n, w_base);
    assign w_any    = w_pick[IDW];
    assign w_win    = w_pick[IDW-1:0];

    always_comb begin
        w_arb_state   = ST_TURN;
        w_arb_pending = w_win;
        w_arb_park    = 1'b0;
        if (w_any && (w_win == owner_q)) begin
            w_arb_state = ST_GRANTED;
        end else if (!w_any) begin
            if (owner_q == PARK_ID) begin
                w_arb_state = ST_PARK;
            end else begin
                w_arb_pending = PARK_ID;
                w_arb_park    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PARK;
            gnt_q       <= ~(NUM_MASTERS'(1) << PARK_ID);
            owner_q     <= PARK_ID;
            last_q      <= LAST_RST;
            pending_q   <= PARK_ID;
            pend_park_q <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            pending_q   <= pending_d;
            pend_park_q <= pend_park_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            timer_q     <= timer_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        pending_d   = pending_q;
        pend_park_d = pend_park_q;
        timer_d     = timer_q;
        case (state_q)
            ST_PARK: begin
                timer_d = '0;
                if (!frame_n) begin
                    state_d = ST_BUSY;
                    last_d  = owner_q;
                end else begin
                    state_d     = w_arb_state;
                    pending_d   = w_arb_pending;
                    pend_park_d = w_arb_park;
                end
            end
            ST_TURN: begin
                if (w_idle) begin
                    state_d = pend_park_q ? ST_PARK : ST_GRANTED;
                    timer_d = '0;
                end
            end
            ST_GRANTED: begin
                if (!frame_n) begin
                    state_d = ST_BUSY;
                    last_d  = owner_q;
                    timer_d = '0;
                end else if (req_n[owner_q] || w_expire) begin
                    state_d     = w_arb_state;
                    pending_d   = w_arb_pending;
                    pend_park_d = w_arb_park;
                    timer_d     = '0;
                    if (w_expire) begin
                        last_d = owner_q;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_BUSY: begin
                if (w_idle) begin
                    state_d     = w_arb_state;
                    pending_d   = w_arb_pending;
                    pend_park_d = w_arb_park;
                    timer_d     = '0;
                end
            end
            default: state_d = ST_PARK;
        endcase
    end

    // Grants only move when leaving TURN, so every owner change crosses an all-high cycle.
    always_comb begin
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        busy_d    = (state_d == ST_BUSY);
        timeout_d = w_expire;
        if (state_d == ST_TURN) begin
            gnt_d = '1;
        end else if (state_q == ST_TURN) begin
            gnt_d   = ~(NUM_MASTERS'(1) << pending_q);
            owner_d = pending_q;
        end
    end

    assign gnt_n    = gnt_q;
    assign owner_id = owner_q;
    assign bus_busy = busy_q;
    assign timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pci_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pci_bus_arbiter
// Description : Directed self-checking bench for pci_bus_arbiter with a
//               queue scoreboard of expected registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pci_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_n;
    logic       frame_n;
    logic       irdy_n;
    logic [3:0] gnt_n;
    logic [1:0] owner_id;
    logic       bus_busy;
    logic       timeout;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic       to;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pci_bus_arbiter #(
        .NUM_MASTERS (4),
        .PARK_MASTER (0),
        .IDLE_TIMEOUT(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_n   (req_n),
        .frame_n (frame_n),
        .irdy_n  (irdy_n),
        .gnt_n   (gnt_n),
        .owner_id(owner_id),
        .bus_busy(bus_busy),
        .timeout (timeout)
    );

    // Drive one cycle of inputs, queue the outputs expected after the edge, then check them.
    task automatic cyc(input logic r, input logic [3:0] rq, input logic fr, input logic ir,
                       input logic [3:0] eg, input logic [1:0] eo, input logic eb,
                       input logic et, input string tag);
        exp_t e;
        exp_t a;
        rst     = r;
        req_n   = rq;
        frame_n = fr;
        irdy_n  = ir;
        e = {eg, eo, eb, et};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        a = {gnt_n, owner_id, bus_busy, timeout};
        total++;
        assert (a === e) else begin
            bad++;
            $error("FAIL %s: observed gnt=%b owner=%0d busy=%b to=%b, expected gnt=%b owner=%0d busy=%b to=%b",
                   tag, a.gnt, a.owner, a.busy, a.to, e.gnt, e.owner, e.busy, e.to);
        end
        total++;
        assert ($countones(~gnt_n) <= 1) else begin
            bad++;
            $error("FAIL %s_onehot: observed gnt=%b, expected at most one low bit", tag, gnt_n);
        end
    endtask

    initial begin
        logic [3:0] g_cur;
        logic [3:0] g_nxt;
        rst     = 1'b1;
        req_n   = 4'b1111;
        frame_n = 1'b1;
        irdy_n  = 1'b1;

        // Reset, including junk inputs that reset must override
        cyc(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, 1'b0, "rst_idle");
        cyc(1'b1, 4'b0000, 1'b0, 1'b0, 4'b1110, 2'd0, 1'b0, 1'b0, "rst_dominates");
        cyc(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, 1'b0, "rst_release");
        cyc(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, 1'b0, "park_idle");

        // Master 2 from park, transaction, then park return
        cyc(1'b0, 4'b1011, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, "m2_turn");
        cyc(1'b0, 4'b1011, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b0, 1'b0, "m2_grant");
        cyc(1'b0, 4'b1011, 1'b0, 1'b0, 4'b1011, 2'd2, 1'b1, 1'b0, "m2_busy1");
        cyc(1'b0, 4'b1111, 1'b0, 1'b0, 4'b1011, 2'd2, 1'b1, 1'b0, "m2_busy2");
        cyc(1'b0, 4'b1111, 1'b0, 1'b0, 4'b1011, 2'd2, 1'b1, 1'b0, "m2_busy3");
        cyc(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1111, 2'd2, 1'b0, 1'b0, "m2_park_turn");
        cyc(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, 1'b0, "m2_parked");

        // All four requesting: order 0,1,2,3,0 with an all-high cycle between owners
        cyc(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, 1'b0, "rr_rst");
        cyc(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, 1'b0, "rr_grant0");
        for (int m = 0; m < 4; m++) begin
            g_cur = ~(4'b0001 << m);
            g_nxt = ~(4'b0001 << ((m + 1) % 4));
            cyc(1'b0, 4'b0000, 1'b0, 1'b0, g_cur, 2'(m), 1'b1, 1'b0, "rr_busy_a");
            cyc(1'b0, 4'b0000, 1'b0, 1'b0, g_cur, 2'(m), 1'b1, 1'b0, "rr_busy_b");
            cyc(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1111, 2'(m), 1'b0, 1'b0, "rr_turn");
            cyc(1'b0, 4'b0000, 1'b1, 1'b1, g_nxt, 2'((m + 1) % 4), 1'b0, 1'b0, "rr_next");
        end

        // Master 1 alone, back-to-back without turnaround
        cyc(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, 1'b0, "b2b_rst");
        cyc(1'b0, 4'b1101, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, "b2b_turn");
        cyc(1'b0, 4'b1101, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0, 1'b0, "b2b_grant");
        cyc(1'b0, 4'b1101, 1'b0, 1'b0, 4'b1101, 2'd1, 1'b1, 1'b0, "b2b_busy1");
        cyc(1'b0, 4'b1101, 1'b0, 1'b0, 4'b1101, 2'd1, 1'b1, 1'b0, "b2b_busy1b");
        cyc(1'b0, 4'b1101, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0, 1'b0, "b2b_idle");
        cyc(1'b0, 4'b1101, 1'b0, 1'b0, 4'b1101, 2'd1, 1'b1, 1'b0, "b2b_busy2");
        cyc(1'b0, 4'b1101, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0, 1'b0, "b2b_idle2");

        // Master 3 granted but idle; master 1 waiting; timeout after 16 cycles
        cyc(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, 1'b0, "to_rst");
        cyc(1'b0, 4'b0111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, "to_turn");
        cyc(1'b0, 4'b0111, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b0, 1'b0, "to_grant3");
        for (int k = 1; k < 16; k++) begin
            cyc(1'b0, 4'b0101, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b0, 1'b0, "to_wait");
        end
        cyc(1'b0, 4'b0101, 1'b1, 1'b1, 4'b1111, 2'd3, 1'b0, 1'b1, "to_pulse");
        cyc(1'b0, 4'b0101, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0, 1'b0, "to_grant1");

        // Reset mid-transaction with master 2 owning the bus
        cyc(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, 1'b0, "mid_rst0");
        cyc(1'b0, 4'b1011, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, "mid_turn");
        cyc(1'b0, 4'b1011, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b0, 1'b0, "mid_grant2");
        cyc(1'b0, 4'b1011, 1'b0, 1'b0, 4'b1011, 2'd2, 1'b1, 1'b0, "mid_busy");
        cyc(1'b1, 4'b1011, 1'b0, 1'b0, 4'b1110, 2'd0, 1'b0, 1'b0, "mid_rst");
        cyc(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, 1'b0, "mid_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
